// File: rtl/count_pwm_pkg.sv
// Shared types and constants for consumers of the 4-bit up/down counter.
package count_pwm_pkg;

    localparam int CNT_W = 4;
    localparam int MAX   = (1 << CNT_W) - 1;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/wrap_detect.sv
// Registers the counter value and direction and flags a genuine wrap-around,
// rejecting loads and holds.
module wrap_detect
    import count_pwm_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_det_o
);

    localparam logic [WIDTH-1:0] CMAX = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] count_q, prev_q;
    logic             dir_q;
    logic [1:0]       vld_q;
    logic             sample_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            prev_q  <= '0;
            dir_q   <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            count_q <= count_i;
            prev_q  <= count_q;
            dir_q   <= dir_i;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // prev_q only holds a real sample once two clocks have passed since reset
    assign sample_valid = vld_q[1];

    assign wrap_det_o = sample_valid &&
        (((dir_q == DIR_ASC)  && (prev_q == CMAX) && (count_q == '0)) ||
         ((dir_q == DIR_DESC) && (prev_q == '0)   && (count_q == CMAX)));

    assign count_o = count_q;

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by the running counter value, with a duty shadow
// register that is applied only at counter wrap-around.
module count_pwm_gen
    import count_pwm_pkg::*;
#(
    parameter int WIDTH  = CNT_W,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              asc_desc,
    input  logic              en,
    input  logic [WIDTH-1:0]  duty_in,
    input  logic              duty_wr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic              duty_pending,
    output logic [PCNT_W-1:0] period_cnt,
    output logic [1:0]        state_o
);

    logic [WIDTH-1:0]  count_q;
    logic              wrap_det;
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d, active_q, active_d, duty_eff;
    logic              pending_q, pending_d, pwm_q, pwm_d, wrap_q;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    wrap_detect #(.WIDTH(WIDTH)) u_wrap (
        .clk_i      (clk),
        .rst_i      (rst),
        .count_i    (count_in),
        .dir_i      (asc_desc),
        .count_o    (count_q),
        .wrap_det_o (wrap_det)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ARMED;
            ARMED:   if (!en) state_d = IDLE;
                     else if (wrap_det) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d  = duty_wr ? duty_in : shadow_q;
        active_d  = wrap_det ? shadow_q : active_q;
        // a write colliding with a wrap lands in the shadow and stays pending
        pending_d = duty_wr | (pending_q & ~wrap_det);
        duty_eff  = wrap_det ? shadow_q : active_q;
        pwm_d     = (state_d == RUN) && (count_q < duty_eff);
        pcnt_d    = (wrap_det && (pcnt_q != '1)) ? pcnt_q + PCNT_W'(1) : pcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            wrap_q    <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            wrap_q    <= wrap_det;
            pcnt_q    <= pcnt_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign wrap_pulse   = wrap_q;
    assign duty_pending = pending_q;
    assign period_cnt   = pcnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed and randomized stimulus for count_pwm_gen against a cycle-level
// reference built from the input history window.
module tb_count_pwm_gen;
    import count_pwm_pkg::*;

    localparam int W  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst, asc_desc, en, duty_wr;
    logic [W-1:0]  count_in, duty_in;
    logic          pwm_out, wrap_pulse, duty_pending;
    logic [PW-1:0] period_cnt;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    count_pwm_gen #(.WIDTH(W), .PCNT_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .asc_desc     (asc_desc),
        .en           (en),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .duty_pending (duty_pending),
        .period_cnt   (period_cnt),
        .state_o      (state_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference state
    state_e m_st = IDLE;
    int     m_shadow = 0, m_active = 0, m_pcnt = 0;
    bit     m_pend = 0, m_pwm = 0, m_wp = 0;
    // input history: index 1 = previous step, 2 = the one before
    int     h_cnt1 = 0, h_cnt2 = 0;
    bit     h_rst1 = 1, h_rst2 = 1, h_dir1 = 0;
    // counter emulation
    int     cur  = 0;
    bit     cdir = 0;
    int     saved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit w, input int di);
        bit     wrap;
        int     eff;
        state_e nxt;
        rst = r; count_in = W'(cur); asc_desc = cdir; en = e; duty_wr = w; duty_in = W'(di);
        @(posedge clk);
        #1;
        // a wrap is judged on the last two samples taken while out of reset
        wrap = !h_rst2 && !h_rst1 &&
               (((h_dir1 == DIR_ASC)  && (h_cnt2 == MAX) && (h_cnt1 == 0)) ||
                ((h_dir1 == DIR_DESC) && (h_cnt2 == 0)   && (h_cnt1 == MAX)));
        if (r) begin
            m_st = IDLE; m_shadow = 0; m_active = 0; m_pcnt = 0;
            m_pend = 0; m_pwm = 0; m_wp = 0;
        end else begin
            nxt = m_st;
            if (!e) nxt = IDLE;
            else if (m_st == IDLE) nxt = ARMED;
            else if (m_st == ARMED && wrap) nxt = RUN;
            eff    = wrap ? m_shadow : m_active;
            m_pwm  = (nxt == RUN) && (h_cnt1 < eff);
            m_wp   = wrap;
            if (wrap) begin
                m_active = m_shadow;
                m_pend   = 0;
                if (m_pcnt < 255) m_pcnt++;
            end
            if (w) begin
                m_shadow = di;
                m_pend   = 1;
            end
            m_st = nxt;
        end
        h_rst2 = h_rst1; h_rst1 = r;
        h_cnt2 = h_cnt1; h_cnt1 = cur; h_dir1 = cdir;
        chk("pwm_out",      32'(pwm_out),      32'(m_pwm));
        chk("wrap_pulse",   32'(wrap_pulse),   32'(m_wp));
        chk("duty_pending", 32'(duty_pending), 32'(m_pend));
        chk("period_cnt",   32'(period_cnt),   32'(m_pcnt));
        chk("state",        32'(state_o),      32'(m_st));
    endtask

    task automatic adv();
        cur = cdir ? (cur + MAX) % (MAX + 1) : (cur + 1) % (MAX + 1);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) begin
            tick(0, e, 0, 0);
            adv();
        end
    endtask

    initial begin
        // 1: reset and idle
        cur = 0; cdir = DIR_ASC;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_state", 32'(state_o), 32'(0));
        run(19, 0);
        chk("idle_pcnt", 32'(period_cnt), 32'(1));

        // 2: arm and run with duty 4
        tick(0, 1, 1, 4);
        adv();
        chk("armed", 32'(state_o), 32'(ARMED));
        run(40, 1);
        chk("run_state", 32'(state_o), 32'(RUN));

        // 3: descending wraps, then a 15 -> 0 load while descending
        cdir = DIR_DESC;
        run(20, 1);
        cur = 5;
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
        saved = m_pcnt;
        cur = 15; tick(0, 1, 0, 0);
        cur = 0;  tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 1, 0, 0);
        chk("false_wrap_pcnt", 32'(period_cnt), 32'(saved));

        // 4: duty write colliding with the wrap cycle
        cdir = DIR_ASC;
        tick(0, 1, 1, 4); adv();
        run(20, 1);
        tick(0, 1, 1, 8); adv();
        while (cur != 15) begin
            tick(0, 1, 0, 0);
            adv();
        end
        tick(0, 1, 0, 0); adv();
        tick(0, 1, 0, 0); adv();
        tick(0, 1, 1, 12); adv();
        chk("collide_pending", 32'(duty_pending), 32'(1));
        run(40, 1);

        // 5: extreme duties, then enable drop mid-period
        tick(0, 1, 1, 0); adv();
        run(40, 1);
        tick(0, 1, 1, 15); adv();
        run(40, 1);
        cur = 6;
        run(3, 0);
        chk("en_drop_state", 32'(state_o), 32'(IDLE));
        chk("en_drop_pwm",   32'(pwm_out), 32'(0));

        // 6: saturation via fast 15/0 toggling, then mid-run reset
        for (int i = 0; i < 620; i++) begin
            cur = (i % 2 == 1) ? 0 : 15;
            tick(0, 1, 0, 0);
        end
        chk("sat_pcnt", 32'(period_cnt), 32'(255));
        cur = 3;
        run(5, 1);
        tick(1, 1, 0, 0); adv();
        chk("mid_rst_pwm",  32'(pwm_out),    32'(0));
        chk("mid_rst_pcnt", 32'(period_cnt), 32'(0));
        run(40, 1);

        // 7: randomized counter behaviour
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int  r;
            bit  e, w, rr;
            r = int'($urandom_range(0, 99));
            if (r < 80) adv();
            else if (r >= 90) cur = int'($urandom_range(0, MAX));
            if ($urandom_range(0, 99) < 3) cdir = ~cdir;
            e  = ($urandom_range(0, 99) < 97) ? en : ~en;
            w  = ($urandom_range(0, 99) < 6);
            rr = ($urandom_range(0, 999) < 4);
            tick(rr, e, w, int'($urandom_range(0, MAX)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
